// File: rtl/disp_scan_ctrl.sv
// Front-panel controller: debounced up/down buttons step the register index and the
// selected 16-bit value is scanned onto a 4-digit active-low seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module disp_scan_ctrl #(
  parameter int unsigned REFRESH_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MAX_REG         = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic [15:0] disp,
  output logic [3:0]  show_reg,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       MAX_IDX  = 4'(MAX_REG);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       rise_q, rise_d;
  logic [DEB_W-1:0] cnt_q [2];
  logic [DEB_W-1:0] cnt_d [2];
  logic [3:0]       show_q, show_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       dig_q, dig_d;
  logic [15:0]      frame_q, frame_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tc_s;
  logic [3:0]       nib_s;
  logic             blank_s;

  // State register for the whole block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      deb_q    <= 2'b00;
      rise_q   <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      show_q   <= 4'd0;
      div_q    <= '0;
      dig_q    <= 2'd0;
      frame_q  <= 16'h0000;
      an_q     <= 4'b1111;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      rise_q   <= rise_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      show_q   <= show_d;
      div_q    <= div_d;
      dig_q    <= dig_d;
      frame_q  <= frame_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  // Synchronise, debounce and detect debounced presses for both buttons.
  always_comb begin
    sync1_d = {btn_dn, btn_up};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    rise_d  = 2'b00;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == DEB_LAST) begin
          deb_d[b]  = sync2_q[b];
          rise_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + DEB_W'(1);
        end
      end else begin
        cnt_d[b] = '0;
      end
    end
  end

  // Register index stepping; simultaneous up and down cancel out.
  always_comb begin
    show_d = show_q;
    case (rise_q)
      2'b01:   show_d = (show_q == MAX_IDX) ? 4'd0 : show_q + 4'd1;
      2'b10:   show_d = (show_q == 4'd0) ? MAX_IDX : show_q - 4'd1;
      default: show_d = show_q;
    endcase
  end

  // Digit scan; the frame is captured only as digit 3 ends so a frame is never torn.
  always_comb begin
    tc_s    = (div_q == DIV_LAST);
    div_d   = tc_s ? '0 : div_q + DIV_W'(1);
    dig_d   = tc_s ? dig_q + 2'd1 : dig_q;
    frame_d = (tc_s && (dig_q == 2'd3)) ? disp : frame_q;
    case (dig_q)
      2'd0:    nib_s = frame_q[3:0];
      2'd1:    nib_s = frame_q[7:4];
      2'd2:    nib_s = frame_q[11:8];
      2'd3:    nib_s = frame_q[15:12];
      default: nib_s = 4'h0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (dig_q)
      2'd1:    blank_s = (frame_q[15:4] == 12'h000);
      2'd2:    blank_s = (frame_q[15:8] == 8'h00);
      2'd3:    blank_s = (frame_q[15:12] == 4'h0);
      default: blank_s = 1'b0;
    endcase
`else
    blank_s = 1'b0;
`endif
    an_d = ~(4'b0001 << dig_q);
    if (blank_s) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = hex_to_seg(nib_s);
    end
    dp_d = ~((dig_q == 2'd0) && (show_q == MAX_IDX));
  end

  assign show_reg = show_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule
